// File: rtl/rob_module_if.sv
// Shared ROB types and the dispatch/write-back/issue/commit bundle around rob_module.
package rob_pkg;
   typedef logic [3:0] nzcv_t;
   typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_MEM, FU_BR} fu_t;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_LSL, ALU_LSR, ALU_MOV, ALU_CMP
   } alu_op_t;
endpackage

interface rob_module_if #(
   parameter int ROB_IDX_W = 3,
   parameter int DATA_W    = 64,
   parameter int REG_IDX_W = 5
);
   import rob_pkg::*;

   // dispatch from the register file
   logic                 in_rf_done;
   logic [REG_IDX_W-1:0] in_rf_dst;
   logic                 in_rf_set_nzcv;
   logic                 in_rf_src1_valid;
   logic                 in_rf_src2_valid;
   logic                 in_rf_nzcv_valid;
   logic [DATA_W-1:0]    in_rf_src1_value;
   logic [DATA_W-1:0]    in_rf_src2_value;
   logic [ROB_IDX_W-1:0] in_rf_src1_rob_index;
   logic [ROB_IDX_W-1:0] in_rf_src2_rob_index;
   logic [ROB_IDX_W-1:0] in_rf_nzcv_rob_index;
   nzcv_t                in_rf_nzcv;
   fu_t                  in_rf_fu_id;
   alu_op_t              in_rf_fu_op;
   logic                 out_rf_full;
   logic [ROB_IDX_W-1:0] out_rf_alloc_rob_index;

   // functional-unit result broadcast
   logic                 in_fu_done;
   logic [ROB_IDX_W-1:0] in_fu_rob_index;
   logic [DATA_W-1:0]    in_fu_value;
   nzcv_t                in_fu_nzcv;

   // resolved instruction to the reservation stations
   logic                 out_rs_done;
   logic [ROB_IDX_W-1:0] out_rs_rob_index;
   logic                 out_rs_src1_valid;
   logic                 out_rs_src2_valid;
   logic                 out_rs_nzcv_valid;
   logic [DATA_W-1:0]    out_rs_src1_value;
   logic [DATA_W-1:0]    out_rs_src2_value;
   logic [ROB_IDX_W-1:0] out_rs_src1_rob_index;
   logic [ROB_IDX_W-1:0] out_rs_src2_rob_index;
   logic [ROB_IDX_W-1:0] out_rs_nzcv_rob_index;
   nzcv_t                out_rs_nzcv;
   fu_t                  out_rs_fu_id;
   alu_op_t              out_rs_fu_op;

   // in-order commit back to the register file
   logic                 out_rf_should_commit;
   logic                 out_rf_set_nzcv;
   nzcv_t                out_rf_nzcv;
   logic [DATA_W-1:0]    out_rf_commit_value;
   logic [REG_IDX_W-1:0] out_rf_reg_index;
   logic [ROB_IDX_W-1:0] out_rf_commit_rob_index;

   // ROB side
   modport slave (
      input  in_rf_done, in_rf_dst, in_rf_set_nzcv,
             in_rf_src1_valid, in_rf_src2_valid, in_rf_nzcv_valid,
             in_rf_src1_value, in_rf_src2_value,
             in_rf_src1_rob_index, in_rf_src2_rob_index, in_rf_nzcv_rob_index,
             in_rf_nzcv, in_rf_fu_id, in_rf_fu_op,
             in_fu_done, in_fu_rob_index, in_fu_value, in_fu_nzcv,
      output out_rf_full, out_rf_alloc_rob_index,
             out_rs_done, out_rs_rob_index,
             out_rs_src1_valid, out_rs_src2_valid, out_rs_nzcv_valid,
             out_rs_src1_value, out_rs_src2_value,
             out_rs_src1_rob_index, out_rs_src2_rob_index, out_rs_nzcv_rob_index,
             out_rs_nzcv, out_rs_fu_id, out_rs_fu_op,
             out_rf_should_commit, out_rf_set_nzcv, out_rf_nzcv,
             out_rf_commit_value, out_rf_reg_index, out_rf_commit_rob_index
   );

   // environment side (register file, functional units, reservation stations)
   modport master (
      output in_rf_done, in_rf_dst, in_rf_set_nzcv,
             in_rf_src1_valid, in_rf_src2_valid, in_rf_nzcv_valid,
             in_rf_src1_value, in_rf_src2_value,
             in_rf_src1_rob_index, in_rf_src2_rob_index, in_rf_nzcv_rob_index,
             in_rf_nzcv, in_rf_fu_id, in_rf_fu_op,
             in_fu_done, in_fu_rob_index, in_fu_value, in_fu_nzcv,
      input  out_rf_full, out_rf_alloc_rob_index,
             out_rs_done, out_rs_rob_index,
             out_rs_src1_valid, out_rs_src2_valid, out_rs_nzcv_valid,
             out_rs_src1_value, out_rs_src2_value,
             out_rs_src1_rob_index, out_rs_src2_rob_index, out_rs_nzcv_rob_index,
             out_rs_nzcv, out_rs_fu_id, out_rs_fu_op,
             out_rf_should_commit, out_rf_set_nzcv, out_rf_nzcv,
             out_rf_commit_value, out_rf_reg_index, out_rf_commit_rob_index
   );
endinterface

// File: rtl/rob_module.sv
// Reorder buffer: allocates entries at dispatch, resolves operands against
// completed entries or a same-cycle result, collects results and commits in order.
module rob_module
   import rob_pkg::*;
#(
   parameter int ROB_IDX_W = 3,
   parameter int DATA_W    = 64,
   parameter int REG_IDX_W = 5
) (
   input logic        in_clk,
   input logic        in_rst_n,
   rob_module_if.slave bus
);
   localparam int                 DEPTH     = 1 << ROB_IDX_W;
   localparam logic [ROB_IDX_W:0] DEPTH_CNT = (ROB_IDX_W+1)'(DEPTH);

   // entry status (reset) and payload (no reset, only read once done/busy)
   logic [DEPTH-1:0]     r_busy;
   logic [DEPTH-1:0]     r_done;
   logic [REG_IDX_W-1:0] r_dst     [DEPTH];
   logic                 r_set_nzcv[DEPTH];
   logic [DATA_W-1:0]    r_value   [DEPTH];
   nzcv_t                r_nzcv    [DEPTH];

   logic [ROB_IDX_W-1:0] r_head;
   logic [ROB_IDX_W-1:0] r_tail;
   logic [ROB_IDX_W:0]   r_count;

   logic                 w_full;
   logic                 w_accept;
   logic                 w_commit;
   logic                 w_wb;

   logic                 w_src1_valid;
   logic                 w_src2_valid;
   logic                 w_nzcv_valid;
   logic [DATA_W-1:0]    w_src1_value;
   logic [DATA_W-1:0]    w_src2_value;
   nzcv_t                w_nzcv;

   // full comes from the pre-edge count, so a commit never frees a slot
   // for a dispatch in the same cycle
   assign w_full   = (r_count == DEPTH_CNT);
   assign w_accept = bus.in_rf_done & ~w_full;
   assign w_commit = (r_count != '0) & r_done[r_head];
   assign w_wb     = bus.in_fu_done & r_busy[bus.in_fu_rob_index]
                   & ~r_done[bus.in_fu_rob_index];

   assign bus.out_rf_full            = w_full;
   assign bus.out_rf_alloc_rob_index = r_tail;

   // src1: architectural value, else completed entry, else same-cycle broadcast
   always_comb begin
      w_src1_valid = bus.in_rf_src1_valid;
      w_src1_value = bus.in_rf_src1_value;
      if (!bus.in_rf_src1_valid) begin
         w_src1_value = '0;
         if (r_done[bus.in_rf_src1_rob_index]) begin
            w_src1_valid = 1'b1;
            w_src1_value = r_value[bus.in_rf_src1_rob_index];
         end else if (bus.in_fu_done && bus.in_fu_rob_index == bus.in_rf_src1_rob_index) begin
            w_src1_valid = 1'b1;
            w_src1_value = bus.in_fu_value;
         end
      end
   end

   // src2: same resolution order as src1
   always_comb begin
      w_src2_valid = bus.in_rf_src2_valid;
      w_src2_value = bus.in_rf_src2_value;
      if (!bus.in_rf_src2_valid) begin
         w_src2_value = '0;
         if (r_done[bus.in_rf_src2_rob_index]) begin
            w_src2_valid = 1'b1;
            w_src2_value = r_value[bus.in_rf_src2_rob_index];
         end else if (bus.in_fu_done && bus.in_fu_rob_index == bus.in_rf_src2_rob_index) begin
            w_src2_valid = 1'b1;
            w_src2_value = bus.in_fu_value;
         end
      end
   end

   // flags: same resolution order, using the nzcv half of each result
   always_comb begin
      w_nzcv_valid = bus.in_rf_nzcv_valid;
      w_nzcv       = bus.in_rf_nzcv;
      if (!bus.in_rf_nzcv_valid) begin
         w_nzcv = '0;
         if (r_done[bus.in_rf_nzcv_rob_index]) begin
            w_nzcv_valid = 1'b1;
            w_nzcv       = r_nzcv[bus.in_rf_nzcv_rob_index];
         end else if (bus.in_fu_done && bus.in_fu_rob_index == bus.in_rf_nzcv_rob_index) begin
            w_nzcv_valid = 1'b1;
            w_nzcv       = bus.in_fu_nzcv;
         end
      end
   end

   // status and pointers; done is left set after commit so a dispatch whose
   // register-file view still points at a just-committed entry resolves
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_busy  <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_wb) r_done[bus.in_fu_rob_index] <= 1'b1;
         if (w_accept) begin
            r_busy[r_tail] <= 1'b1;
            r_done[r_tail] <= 1'b0;
            r_tail         <= r_tail + 1'b1;
         end
         if (w_commit) begin
            r_busy[r_head] <= 1'b0;
            r_head         <= r_head + 1'b1;
         end
         case ({w_accept, w_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // entry payload captured at dispatch and at write-back
   always_ff @(posedge in_clk) begin
      if (w_accept) begin
         r_dst[r_tail]      <= bus.in_rf_dst;
         r_set_nzcv[r_tail] <= bus.in_rf_set_nzcv;
      end
      if (w_wb) begin
         r_value[bus.in_fu_rob_index] <= bus.in_fu_value;
         r_nzcv[bus.in_fu_rob_index]  <= bus.in_fu_nzcv;
      end
   end

   // registered issue to the reservation stations, one-cycle pulse per dispatch
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         bus.out_rs_done           <= 1'b0;
         bus.out_rs_rob_index      <= '0;
         bus.out_rs_src1_valid     <= 1'b0;
         bus.out_rs_src2_valid     <= 1'b0;
         bus.out_rs_nzcv_valid     <= 1'b0;
         bus.out_rs_src1_value     <= '0;
         bus.out_rs_src2_value     <= '0;
         bus.out_rs_src1_rob_index <= '0;
         bus.out_rs_src2_rob_index <= '0;
         bus.out_rs_nzcv_rob_index <= '0;
         bus.out_rs_nzcv           <= '0;
         bus.out_rs_fu_id          <= FU_ALU;
         bus.out_rs_fu_op          <= ALU_ADD;
      end else begin
         bus.out_rs_done <= w_accept;
         if (w_accept) begin
            bus.out_rs_rob_index      <= r_tail;
            bus.out_rs_src1_valid     <= w_src1_valid;
            bus.out_rs_src2_valid     <= w_src2_valid;
            bus.out_rs_nzcv_valid     <= w_nzcv_valid;
            bus.out_rs_src1_value     <= w_src1_value;
            bus.out_rs_src2_value     <= w_src2_value;
            bus.out_rs_src1_rob_index <= bus.in_rf_src1_rob_index;
            bus.out_rs_src2_rob_index <= bus.in_rf_src2_rob_index;
            bus.out_rs_nzcv_rob_index <= bus.in_rf_nzcv_rob_index;
            bus.out_rs_nzcv           <= w_nzcv;
            bus.out_rs_fu_id          <= bus.in_rf_fu_id;
            bus.out_rs_fu_op          <= bus.in_rf_fu_op;
         end
      end
   end

   // registered commit port; payload holds between commit pulses
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         bus.out_rf_should_commit    <= 1'b0;
         bus.out_rf_set_nzcv         <= 1'b0;
         bus.out_rf_nzcv             <= '0;
         bus.out_rf_commit_value     <= '0;
         bus.out_rf_reg_index        <= '0;
         bus.out_rf_commit_rob_index <= '0;
      end else begin
         bus.out_rf_should_commit <= w_commit;
         if (w_commit) begin
            bus.out_rf_set_nzcv         <= r_set_nzcv[r_head];
            bus.out_rf_nzcv             <= r_nzcv[r_head];
            bus.out_rf_commit_value     <= r_value[r_head];
            bus.out_rf_reg_index        <= r_dst[r_head];
            bus.out_rf_commit_rob_index <= r_head;
         end
      end
   end

endmodule

// File: tb/tb_rob_module.sv
// Scoreboard bench for rob_module: issue and commit expectations are queued as
// stimulus is driven and compared when the DUT pulses the matching output.
module tb_rob_module;
   import rob_pkg::*;

   localparam int ROB_IDX_W = 3;
   localparam int DATA_W    = 64;
   localparam int REG_IDX_W = 5;

   logic in_clk   = 1'b0;
   logic in_rst_n = 1'b0;
   always #5 in_clk = ~in_clk;

   rob_module_if #(.ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) bus ();

   rob_module #(.ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) dut (
      .in_clk  (in_clk),
      .in_rst_n(in_rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [2:0]  idx;
      logic        s1v;  logic [63:0] s1; logic [2:0] t1;
      logic        s2v;  logic [63:0] s2; logic [2:0] t2;
      logic        nzv;  logic [3:0]  nz; logic [2:0] nt;
      logic [3:0]  op;
   } rs_exp_t;

   typedef struct {
      logic [4:0]  rg;
      logic [63:0] val;
      logic [2:0]  idx;
      logic        setn;
      logic [3:0]  nz;
   } cm_exp_t;

   rs_exp_t    rs_q[$];
   cm_exp_t    cm_q[$];
   rs_exp_t    me;
   cm_exp_t    mc;
   logic [3:0] cur_op;
   int         n_chk = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge in_clk);
      #1;
   endtask

   task automatic idle();
      bus.in_rf_done = 1'b0; bus.in_rf_dst = '0; bus.in_rf_set_nzcv = 1'b0;
      bus.in_rf_src1_valid = 1'b0; bus.in_rf_src2_valid = 1'b0; bus.in_rf_nzcv_valid = 1'b0;
      bus.in_rf_src1_value = '0; bus.in_rf_src2_value = '0; bus.in_rf_nzcv = '0;
      bus.in_rf_src1_rob_index = '0; bus.in_rf_src2_rob_index = '0; bus.in_rf_nzcv_rob_index = '0;
      bus.in_rf_fu_id = FU_ALU; bus.in_rf_fu_op = ALU_ADD;
      bus.in_fu_done = 1'b0; bus.in_fu_rob_index = '0; bus.in_fu_value = '0; bus.in_fu_nzcv = '0;
   endtask

   task automatic disp_raw(input logic [4:0] dst, input logic setn,
                           input logic s1v, input logic [63:0] s1, input logic [2:0] t1,
                           input logic s2v, input logic [63:0] s2, input logic [2:0] t2,
                           input logic nzv, input logic [3:0] nz, input logic [2:0] nt);
      cur_op = {1'b0, dst[2:0]};
      bus.in_rf_done = 1'b1; bus.in_rf_dst = dst; bus.in_rf_set_nzcv = setn;
      bus.in_rf_src1_valid = s1v; bus.in_rf_src1_value = s1; bus.in_rf_src1_rob_index = t1;
      bus.in_rf_src2_valid = s2v; bus.in_rf_src2_value = s2; bus.in_rf_src2_rob_index = t2;
      bus.in_rf_nzcv_valid = nzv; bus.in_rf_nzcv = nz; bus.in_rf_nzcv_rob_index = nt;
      bus.in_rf_fu_id = FU_MUL; bus.in_rf_fu_op = alu_op_t'(cur_op);
   endtask

   task automatic exp_rs(input logic [2:0] idx,
                         input logic s1v, input logic [63:0] s1, input logic [2:0] t1,
                         input logic s2v, input logic [63:0] s2, input logic [2:0] t2,
                         input logic nzv, input logic [3:0] nz, input logic [2:0] nt);
      rs_exp_t e;
      e.idx = idx; e.s1v = s1v; e.s1 = s1; e.t1 = t1; e.s2v = s2v; e.s2 = s2; e.t2 = t2;
      e.nzv = nzv; e.nz = nz; e.nt = nt; e.op = cur_op;
      rs_q.push_back(e);
   endtask

   task automatic exp_cm(input logic [4:0] rg, input logic [63:0] val, input logic [2:0] idx,
                         input logic setn, input logic [3:0] nz);
      cm_exp_t e;
      e.rg = rg; e.val = val; e.idx = idx; e.setn = setn; e.nz = nz;
      cm_q.push_back(e);
   endtask

   // dispatch with every operand architectural; nzcv carries the dst number
   task automatic disp_v(input logic [4:0] dst, input logic setn, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] idx);
      disp_raw(dst, setn, 1'b1, a, 3'd0, 1'b1, b, 3'd0, 1'b1, dst[3:0], 3'd0);
      exp_rs(idx, 1'b1, a, 3'd0, 1'b1, b, 3'd0, 1'b1, dst[3:0], 3'd0);
   endtask

   task automatic wb(input logic [2:0] idx, input logic [63:0] val, input logic [3:0] nz);
      bus.in_fu_done = 1'b1; bus.in_fu_rob_index = idx; bus.in_fu_value = val; bus.in_fu_nzcv = nz;
   endtask

   task automatic do_reset();
      in_rst_n = 1'b0;
      rs_q.delete();
      cm_q.delete();
      #3;
      in_rst_n = 1'b1;
      cyc();
   endtask

   // output monitor: every pulse must match the oldest queued expectation
   always @(negedge in_clk) begin
      if (in_rst_n) begin
         if (bus.out_rs_done) begin
            if (rs_q.size() == 0) chk("rs_unexpected", 64'd1, 64'd0);
            else begin
               me = rs_q.pop_front();
               chk("rs_idx", 64'(bus.out_rs_rob_index), 64'(me.idx));
               chk("rs_s1v", 64'(bus.out_rs_src1_valid), 64'(me.s1v));
               if (me.s1v) chk("rs_s1val", bus.out_rs_src1_value, me.s1);
               chk("rs_t1", 64'(bus.out_rs_src1_rob_index), 64'(me.t1));
               chk("rs_s2v", 64'(bus.out_rs_src2_valid), 64'(me.s2v));
               if (me.s2v) chk("rs_s2val", bus.out_rs_src2_value, me.s2);
               chk("rs_t2", 64'(bus.out_rs_src2_rob_index), 64'(me.t2));
               chk("rs_nzv", 64'(bus.out_rs_nzcv_valid), 64'(me.nzv));
               if (me.nzv) chk("rs_nzcv", 64'(bus.out_rs_nzcv), 64'(me.nz));
               chk("rs_nt", 64'(bus.out_rs_nzcv_rob_index), 64'(me.nt));
               chk("rs_fu", 64'(bus.out_rs_fu_id), 64'(FU_MUL));
               chk("rs_op", 64'(bus.out_rs_fu_op), 64'(me.op));
            end
         end
         if (bus.out_rf_should_commit) begin
            if (cm_q.size() == 0) chk("cm_unexpected", 64'd1, 64'd0);
            else begin
               mc = cm_q.pop_front();
               chk("cm_reg", 64'(bus.out_rf_reg_index), 64'(mc.rg));
               chk("cm_val", bus.out_rf_commit_value, mc.val);
               chk("cm_idx", 64'(bus.out_rf_commit_rob_index), 64'(mc.idx));
               chk("cm_setn", 64'(bus.out_rf_set_nzcv), 64'(mc.setn));
               chk("cm_nzcv", 64'(bus.out_rf_nzcv), 64'(mc.nz));
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle();
      cur_op = '0;
      #12;
      chk("rst_full", 64'(bus.out_rf_full), 64'd0);
      chk("rst_alloc", 64'(bus.out_rf_alloc_rob_index), 64'd0);
      chk("rst_rs_done", 64'(bus.out_rs_done), 64'd0);
      chk("rst_commit", 64'(bus.out_rf_should_commit), 64'd0);
      in_rst_n = 1'b1;
      cyc();

      // basic dispatch, operands already architectural
      disp_v(5'd3, 1'b0, 64'd5, 64'd7, 3'd0);
      cyc(); idle();
      chk("alloc_after_first", 64'(bus.out_rf_alloc_rob_index), 64'd1);

      // write-back to head, commit one cycle later
      wb(3'd0, 64'd42, 4'h0);
      cyc(); idle();
      exp_cm(5'd3, 64'd42, 3'd0, 1'b0, 4'h0);
      chk("commit_not_yet", 64'(bus.out_rf_should_commit), 64'd0);
      cyc();
      chk("commit_pulse", 64'(bus.out_rf_should_commit), 64'd1);
      chk("commit_idx0", 64'(bus.out_rf_commit_rob_index), 64'd0);
      cyc();
      chk("commit_single", 64'(bus.out_rf_should_commit), 64'd0);
      chk("empty_not_full", 64'(bus.out_rf_full), 64'd0);

      // fill, drop when full, commit+dispatch in a full cycle, wrap
      do_reset();
      for (int i = 0; i < 8; i++) begin
         disp_v(5'(i + 8), 1'b0, 64'(i), 64'(i + 100), 3'(i));
         if (i < 7) begin
            cyc();
            chk("not_full_yet", 64'(bus.out_rf_full), 64'd0);
         end else cyc();
      end
      idle();
      chk("full_at_8", 64'(bus.out_rf_full), 64'd1);
      chk("alloc_wrap", 64'(bus.out_rf_alloc_rob_index), 64'd0);
      disp_raw(5'd30, 1'b0, 1'b1, 64'd1, 3'd0, 1'b1, 64'd2, 3'd0, 1'b1, 4'h0, 3'd0);
      cyc(); idle();
      chk("full_after_drop", 64'(bus.out_rf_full), 64'd1);
      chk("alloc_after_drop", 64'(bus.out_rf_alloc_rob_index), 64'd0);
      wb(3'd0, 64'd55, 4'h3);
      cyc(); idle();
      exp_cm(5'd8, 64'd55, 3'd0, 1'b0, 4'h3);
      disp_raw(5'd31, 1'b0, 1'b1, 64'd1, 3'd0, 1'b1, 64'd2, 3'd0, 1'b1, 4'h0, 3'd0);
      cyc(); idle();
      chk("full_cleared", 64'(bus.out_rf_full), 64'd0);
      chk("alloc_refused", 64'(bus.out_rf_alloc_rob_index), 64'd0);
      disp_v(5'd20, 1'b0, 64'd1, 64'd2, 3'd0);
      cyc(); idle();
      chk("full_again", 64'(bus.out_rf_full), 64'd1);

      // operand resolution from done entries and same-cycle broadcast
      do_reset();
      for (int i = 0; i < 5; i++) begin
         disp_v(5'(i), (i == 2), 64'(i + 1000), 64'(i + 2000), 3'(i));
         cyc();
      end
      idle();
      wb(3'd2, 64'd9, 4'h9);
      cyc(); idle();
      disp_raw(5'd6, 1'b0, 1'b0, 64'd0, 3'd2, 1'b0, 64'd0, 3'd4, 1'b0, 4'h0, 3'd3);
      wb(3'd4, 64'd77, 4'h7);
      exp_rs(3'd5, 1'b1, 64'd9, 3'd2, 1'b1, 64'd77, 3'd4, 1'b0, 4'h0, 3'd3);
      cyc(); idle();
      disp_raw(5'd7, 1'b0, 1'b0, 64'd0, 3'd3, 1'b1, 64'd123, 3'd0, 1'b0, 4'h0, 3'd2);
      exp_rs(3'd6, 1'b0, 64'd0, 3'd3, 1'b1, 64'd123, 3'd0, 1'b1, 4'h9, 3'd2);
      cyc(); idle();

      // out-of-order completion commits in program order
      wb(3'd1, 64'd11, 4'h1);
      cyc(); idle();
      cyc();
      chk("no_commit_ooo", 64'(bus.out_rf_should_commit), 64'd0);
      wb(3'd0, 64'd10, 4'h0);
      exp_cm(5'd0, 64'd10, 3'd0, 1'b0, 4'h0);
      exp_cm(5'd1, 64'd11, 3'd1, 1'b0, 4'h1);
      exp_cm(5'd2, 64'd9,  3'd2, 1'b1, 4'h9);
      cyc(); idle();
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("inorder_pulse", 64'(bus.out_rf_should_commit), 64'd1);
         chk("inorder_idx", 64'(bus.out_rf_commit_rob_index), 64'(i));
      end
      cyc();
      chk("stop_at_undone", 64'(bus.out_rf_should_commit), 64'd0);

      // asynchronous reset with five entries busy and an issue pulse in flight
      disp_v(5'd9, 1'b0, 64'd1, 64'd2, 3'd7);
      cyc(); idle();
      #2;
      in_rst_n = 1'b0;
      #1;
      rs_q.delete();
      cm_q.delete();
      chk("arst_rs_done", 64'(bus.out_rs_done), 64'd0);
      chk("arst_full", 64'(bus.out_rf_full), 64'd0);
      chk("arst_alloc", 64'(bus.out_rf_alloc_rob_index), 64'd0);
      chk("arst_commit_idx", 64'(bus.out_rf_commit_rob_index), 64'd0);
      chk("arst_commit_reg", 64'(bus.out_rf_reg_index), 64'd0);
      #4;
      in_rst_n = 1'b1;
      cyc();

      // write-back to a free entry is ignored, so tag 0 stays unresolved
      wb(3'd0, 64'd99, 4'hf);
      cyc(); idle();
      disp_raw(5'd1, 1'b0, 1'b0, 64'd0, 3'd0, 1'b1, 64'd3, 3'd0, 1'b1, 4'h2, 3'd0);
      exp_rs(3'd0, 1'b0, 64'd0, 3'd0, 1'b1, 64'd3, 3'd0, 1'b1, 4'h2, 3'd0);
      cyc(); idle();
      chk("alloc_post_reset", 64'(bus.out_rf_alloc_rob_index), 64'd1);

      repeat (3) cyc();
      chk("rs_q_drained", 64'(rs_q.size()), 64'd0);
      chk("cm_q_drained", 64'(cm_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rob_module.md
# rob_module

Reorder buffer for the Tomasulo core. It accepts renamed instructions from the register file, assigns each an entry, and resolves source operands against completed-but-uncommitted results. It forwards the resolved instruction to the reservation stations and collects functional-unit results. Completed entries commit in program order back to the register file over the commit port that `reg_module` consumes.

## Interface
Parameters:
- `ROB_IDX_W`, default 3: entry index width; depth = 2**ROB_IDX_W.
- `DATA_W`, default 64: GPR value width.
- `REG_IDX_W`, default 5: GPR index width.

Ports (nzcv_t = 4 bits; fu_t and alu_op_t are the shared enums):
- `in_clk` in 1: clock; all state updates on the rising edge.
- `in_rst_n` in 1: reset, asynchronous, active-low.
- `in_rf_done` in 1: dispatch valid from the register file.
- `in_rf_dst` in REG_IDX_W: destination GPR.
- `in_rf_set_nzcv` in 1: the instruction writes flags.
- `in_rf_src1_valid`, `in_rf_src2_valid`, `in_rf_nzcv_valid` in 1 each: operand already architectural.
- `in_rf_src1_value`, `in_rf_src2_value` in DATA_W: operand values when valid.
- `in_rf_src1_rob_index`, `in_rf_src2_rob_index`, `in_rf_nzcv_rob_index` in ROB_IDX_W: producer tags when not valid.
- `in_rf_nzcv` in nzcv_t: flags when valid.
- `in_rf_fu_id` in fu_t: target functional unit.
- `in_rf_fu_op` in alu_op_t: functional-unit operation.
- `out_rf_full` out 1: no free entry; dispatch is refused.
- `out_rf_alloc_rob_index` out ROB_IDX_W: tail index that the next accepted dispatch receives (combinational from tail).
- `in_fu_done` in 1: result broadcast valid.
- `in_fu_rob_index` in ROB_IDX_W: entry the result belongs to.
- `in_fu_value` in DATA_W: result value.
- `in_fu_nzcv` in nzcv_t: result flags.
- `out_rs_done` out 1: resolved instruction valid for the reservation stations.
- `out_rs_rob_index` out ROB_IDX_W: the instruction's own entry.
- `out_rs_src1_valid`, `out_rs_src2_valid`, `out_rs_nzcv_valid` out 1 each: operand resolved.
- `out_rs_src1_value`, `out_rs_src2_value` out DATA_W: resolved operand values.
- `out_rs_src1_rob_index`, `out_rs_src2_rob_index`, `out_rs_nzcv_rob_index` out ROB_IDX_W: tags to wait on when unresolved.
- `out_rs_nzcv` out nzcv_t: resolved flags.
- `out_rs_fu_id` out fu_t and `out_rs_fu_op` out alu_op_t: passed through from dispatch.
- `out_rf_should_commit` out 1: commit pulse.
- `out_rf_set_nzcv` out 1: the committed instruction writes flags.
- `out_rf_nzcv` out nzcv_t: committed flags.
- `out_rf_commit_value` out DATA_W: committed value.
- `out_rf_reg_index` out REG_IDX_W: committed destination GPR.
- `out_rf_commit_rob_index` out ROB_IDX_W: committed entry.

## Operation
- Each entry holds: busy, done, dst, set_nzcv, value, nzcv.
- State: head, tail (ROB_IDX_W, wrap modulo depth); count (ROB_IDX_W+1 bits, 0..depth).
- `out_rf_full` = (count == depth).
- Dispatch is accepted when `in_rf_done` is high and `out_rf_full` is low.
  - On acceptance: entry[tail] gets busy=1, done=0, dst and set_nzcv; tail increments.
  - A dispatch while full is dropped; no state change and `out_rs_done` stays low.
- Operand resolution at dispatch, applied independently per src1, src2 and nzcv:
  - If the operand is already valid, pass it through.
  - Else if the referenced entry has done=1, output its value or nzcv and mark the operand valid.
  - Else if `in_fu_done` is high with a matching index this same cycle, output `in_fu_value` or `in_fu_nzcv` and mark valid.
  - Otherwise output the tag with valid=0.
- Write-back: on `in_fu_done` to an entry with busy=1 and done=0, store value and nzcv and set done=1.
  - Write-back to a non-busy or already-done entry is ignored.
- Commit: if count>0 and entry[head] has done=1:
  - Register the commit outputs from entry[head] with `out_rf_should_commit`=1.
  - Clear busy, increment head.
  - At most one commit per cycle.
  - Otherwise `out_rf_should_commit`=0 and the other commit outputs hold their values.
- Count update per edge: +1 on an accepted dispatch, −1 on a commit; both together leave it unchanged.
- Full is evaluated from the pre-edge count. A commit and a dispatch in the same full cycle therefore commits and refuses the dispatch.
- Reset (asynchronous, any time, including mid-operation): head=tail=count=0, all busy and done cleared, every output 0. `out_rf_alloc_rob_index` therefore reads 0 and `out_rf_full` reads 0.

## Timing
- Dispatch accepted at edge N → `out_rs_*` valid in cycle N+1, a single-cycle pulse.
- Write-back at edge N → entry done at edge N. If that entry is head, `out_rf_should_commit` is high in cycle N+1.
- Dispatch → commit minimum latency: dispatch at edge N, write-back in cycle N+1, commit pulse in cycle N+2.
- Back-to-back dispatch at one per cycle is sustained until full.
- Write-back to the head entry and a new dispatch in the same cycle are handled simultaneously.

## Test plan
- Reset, then dispatch dst=3 with both sources valid (5, 7) → cycle+1: `out_rs_done`=1, rob_index=0, values 5/7; `out_rf_alloc_rob_index`=1.
- Dispatch to entry 0, write-back to 0 with value 42 → next cycle: should_commit=1, reg_index=3, value=42, commit_rob_index=0; count returns to 0.
- Dispatch 8 instructions with DEPTH=8 → `out_rf_full`=1 and a 9th dispatch is dropped. Commit one → full=0 and the next dispatch gets index 0 (wrap).
- Entry 2 done with value 9; dispatch src1 invalid with tag 2 → `out_rs_src1_valid`=1, value 9. Same-cycle write-back to tag 4 with src2 tag 4 → src2 valid with the forwarded value.
- Write-back to entry 1 before entry 0 → no commit. Then write-back to 0 → commits 0 and 1 in consecutive cycles, in order.
- Drop `in_rst_n` mid-operation with 5 entries busy → outputs 0 immediately, no clock needed; after release the first dispatch gets index 0.
